// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART framing constants and receiver state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// uart_sync : two-flop synchroniser for an asynchronous single-bit input
// Revision  : 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx  : 8N1 UART receiver with one-entry valid/ready holding register
//            Optional 2-of-3 majority sampling via UART_RX_MAJORITY_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       ser_i,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic [7:0] data_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int WND_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_OFS = 1;
`else
    localparam int MAJ_OFS = 0;
`endif
    // Majority voting delays only the start decision; later decisions stay CLKS_PER_BIT apart.
    localparam logic [WND_W-1:0] START_TGT = WND_W'(HALF - 1 + MAJ_OFS);
    localparam logic [WND_W-1:0] BIT_TGT   = WND_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cpb_too_small
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
`ifdef UART_RX_MAJORITY_EN
    if (CLKS_PER_BIT < 8) begin : g_cpb_too_small_maj
        $error("uart_rx: majority sampling needs CLKS_PER_BIT >= 8");
    end
`endif

    logic rx_s;
    logic smp;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ser_i),
        .q_o    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign smp = maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign smp = rx_s;
`endif

    uart_rx_state_t            state_q, state_d;
    logic [WND_W-1:0]          wnd_q, wnd_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      brk_q, brk_d;
    logic                      load;

    always_comb begin
        state_d = state_q;
        wnd_d   = wnd_q + WND_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        load    = 1'b0;
        // A held break must see the line high before a new start is accepted.
        brk_d   = brk_q & ~rx_s;

        if (!en_i) begin
            state_d = RX_IDLE;
            wnd_d   = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    wnd_d = '0;
                    if (rx_s == UART_START_BIT && !brk_q) begin
                        state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (wnd_q == START_TGT) begin
                        wnd_d   = '0;
                        bit_d   = 3'd0;
                        state_d = (smp == UART_START_BIT) ? RX_DATA : RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (wnd_q == BIT_TGT) begin
                        wnd_d   = '0;
                        shreg_d = {smp, shreg_q[UART_DATA_BITS-1:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                            state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (wnd_q == BIT_TGT) begin
                        wnd_d   = '0;
                        state_d = RX_IDLE;
                        if (smp == UART_STOP_BIT) begin
                            if (!valid_q || data_ready_i) begin
                                load = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                    wnd_d   = '0;
                end
            endcase
        end

        data_d  = load ? shreg_q : data_q;
        valid_d = load | (valid_q & ~data_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            wnd_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wnd_q   <= wnd_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            brk_q   <= brk_d;
        end
    end

    assign data_valid_o = valid_q;
    assign data_o       = data_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : randomized self-checking bench for uart_rx against a frame-level model
// Revision   : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b1;
    logic       ser_i = 1'b1;
    logic       data_ready_i = 1'b1;
    logic       data_valid_o;
    logic [7:0] data_o;
    logic       frame_err_o;
    logic       overrun_o;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .ser_i        (ser_i),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_o       (data_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    int total = 0;
    int bad   = 0;

    // Observed stream: every accepted byte, every pulse cycle, every invariant breach.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         viol_cnt = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst_ni) begin
            if (data_valid_o && data_ready_i) rx_q.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (frame_err_o && overrun_o) viol_cnt++;
            if (prev_hold && data_o !== prev_data) viol_cnt++;
            prev_hold = data_valid_o && !data_ready_i;
            prev_data = data_o;
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic int qget(input int i);
        return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
    endtask

    task automatic send_bit(input logic b, input logic spike);
        for (int i = 0; i < CPB; i++) begin
            ser_i = (spike && i == 8) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic spike);
        send_bit(1'b0, spike);
        for (int i = 0; i < 8; i++) send_bit(d[i], spike);
        send_bit(stop, spike);
        ser_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle(4);
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun_o); end
        rst_ni = 1'b1;
        idle(4);
    endtask

    task automatic test_single();
        clear_obs();
        data_ready_i = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(30);
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", rx_q.size()); end
        total++; if (qget(0) !== 32'hA5) begin bad++; $display("FAIL single_data got=%0h want=a5", qget(0)); end
        total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL single_flags got=%0d want=0", ferr_cnt + ovr_cnt); end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%b want=0", data_valid_o); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        exp_q = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 1'b0);
        idle(30);
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++; if (qget(i) !== int'(exp_q[i])) begin bad++; $display("FAIL b2b_data[%0d] got=%0h want=%0h", i, qget(i), exp_q[i]); end
        end
        total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL b2b_flags got=%0d want=0", ferr_cnt + ovr_cnt); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        clear_obs();
        ser_i = 1'b0;
        idle(4);
        ser_i = 1'b1;
        idle(3 * CPB);
        total++; if (rx_q.size() + ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL glitch_quiet got=%0d want=0", rx_q.size() + ferr_cnt + ovr_cnt); end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", data_valid_o); end
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0);
        idle(30);
        total++; if (qget(0) !== int'(d) || rx_q.size() !== 1) begin bad++; $display("FAIL glitch_recover got=%0h want=%0h", qget(0), d); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        clear_obs();
        send_frame(8'h3C, 1'b0, 1'b0);
        ser_i = 1'b0;
        idle(3 * CPB);
        ser_i = 1'b1;
        idle(3 * CPB);
        total++; if (ferr_cnt !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", ferr_cnt); end
        total++; if (rx_q.size() !== 0 || data_valid_o !== 1'b0) begin bad++; $display("FAIL ferr_no_data got=%0d want=0", rx_q.size()); end
        total++; if (ovr_cnt !== 0) begin bad++; $display("FAIL ferr_no_ovr got=%0d want=0", ovr_cnt); end
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0);
        idle(30);
        total++; if (qget(0) !== int'(d) || rx_q.size() !== 1) begin bad++; $display("FAIL ferr_recover got=%0h want=%0h", qget(0), d); end
    endtask

    task automatic test_overrun();
        clear_obs();
        data_ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(30);
        total++; if (data_valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", data_valid_o); end
        total++; if (data_o !== 8'h11) begin bad++; $display("FAIL ovr_kept got=%h want=11", data_o); end
        total++; if (ovr_cnt !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr_cnt); end
        total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL ovr_no_ferr got=%0d want=0", ferr_cnt); end
        data_ready_i = 1'b1;
        idle(1);
        data_ready_i = 1'b0;
        idle(2);
        total++; if (qget(0) !== 32'h11 || rx_q.size() !== 1) begin bad++; $display("FAIL ovr_drain got=%0h want=11", qget(0)); end
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL ovr_fall got=%b want=0", data_valid_o); end
        data_ready_i = 1'b1;
    endtask

    task automatic test_drain_and_load();
        logic [7:0] a, b;
        clear_obs();
        a = 8'($urandom);
        b = 8'($urandom);
        data_ready_i = 1'b0;
        send_frame(a, 1'b1, 1'b0);
        idle(10);
        // Ready is high only at the edge where the second byte's stop sample loads.
        fork
            send_frame(b, 1'b1, 1'b0);
            begin
                repeat (154 + MAJ) @(posedge clk);
                #1 data_ready_i = 1'b1;
                @(posedge clk);
                #1 data_ready_i = 1'b0;
            end
        join
        idle(10);
        total++; if (ovr_cnt !== 0) begin bad++; $display("FAIL dl_no_ovr got=%0d want=0", ovr_cnt); end
        total++; if (qget(0) !== int'(a) || rx_q.size() !== 1) begin bad++; $display("FAIL dl_first got=%0h want=%0h", qget(0), a); end
        total++; if (data_valid_o !== 1'b1 || data_o !== b) begin bad++; $display("FAIL dl_second got=%b/%h want=1/%h", data_valid_o, data_o, b); end
        data_ready_i = 1'b1;
        idle(4);
    endtask

    task automatic test_enable();
        clear_obs();
        data_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        en_i  = 1'b0;
        ser_i = 1'b1;
        idle(20);
        en_i = 1'b1;
        idle(CPB);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(30);
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL en_count got=%0d want=1", rx_q.size()); end
        total++; if (qget(0) !== 32'h7E) begin bad++; $display("FAIL en_data got=%0h want=7e", qget(0)); end
        total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL en_flags got=%0d want=0", ferr_cnt + ovr_cnt); end
    endtask

    task automatic test_random_ready();
        bit done = 1'b0;
        clear_obs();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom));
        fork
            begin
                foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 1'b0);
                idle(40);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    data_ready_i = ($urandom_range(0, 3) == 0);
                    @(posedge clk);
                    #1;
                end
                data_ready_i = 1'b1;
            end
        join
        idle(4);
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++; if (qget(i) !== int'(exp_q[i])) begin bad++; $display("FAIL rnd_data[%0d] got=%0h want=%0h", i, qget(i), exp_q[i]); end
        end
        total++; if (ovr_cnt + ferr_cnt !== 0) begin bad++; $display("FAIL rnd_flags got=%0d want=0", ovr_cnt + ferr_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_obs();
        data_ready_i = 1'b0;
        send_frame(8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        total++; if (data_valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", data_valid_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", data_o); end
        ser_i = 1'b1;
        data_ready_i = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(4);
        clear_obs();
        d = 8'($urandom);
        send_frame(d, 1'b1, 1'b0);
        idle(30);
        total++; if (qget(0) !== int'(d) || rx_q.size() !== 1) begin bad++; $display("FAIL rstmid_recover got=%0h want=%0h", qget(0), d); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        clear_obs();
        exp_q = '{8'hC3};
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 1'b1);
        idle(30);
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL maj_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            total++; if (qget(i) !== int'(exp_q[i])) begin bad++; $display("FAIL maj_data[%0d] got=%0h want=%0h", i, qget(i), exp_q[i]); end
        end
        total++; if (ferr_cnt + ovr_cnt !== 0) begin bad++; $display("FAIL maj_flags got=%0d want=0", ferr_cnt + ovr_cnt); end
    endtask
`endif

    task automatic test_invariants();
        total++; if (viol_cnt !== 0) begin bad++; $display("FAIL invariants got=%0d want=0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_drain_and_load();
        test_enable();
        test_random_ready();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
